// File: rtl/fib_gen.sv
// fib_gen - parametrised Fibonacci pattern source with valid/ready output.
//
// Produces seed0, seed1, seed0+seed1, ... one term per accepted handshake.
// The sequence restarts from the captured seeds after MAX_TERMS terms
// (MAX_TERMS = 0 disables the limit).
//
// Optional feature macro: FIB_STOP_ON_OVF_EN
//   defined     : an overflowing term sends the FSM to DONE (output stops)
//   not defined : an overflowing term wraps the sequence back to the seeds
// In both cases ovf is sticky until the next accepted start or reset.
//
// Parameters
//   WIDTH     term width in bits (>= 2)
//   MAX_TERMS terms per sequence before wrap to seeds, 0 = unlimited
//   IDX_W     term index width (must hold MAX_TERMS-1)
//
// Ports
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    start/restart request (level, sampled each cycle)
//   stop     return to IDLE (level, wins over start)
//   seed0    first term, captured on accepted start
//   seed1    second term, captured on accepted start
//   y        current term
//   y_valid  y holds a valid term
//   y_ready  consumer accepts y when y_valid & y_ready
//   idx      index of current term (0 = seed0)
//   ovf      sticky overflow flag
//   busy     FSM is in RUN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no output; y/idx hold last values
// RUN   | presenting terms, advancing on each handshake
// DONE  | stopped after overflow (only with FIB_STOP_ON_OVF_EN)

module fib_gen #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 13,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [IDX_W-1:0] idx,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam bit               LIMIT_EN = (MAX_TERMS != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((MAX_TERMS == 0) ? 0 : MAX_TERMS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s0, s1;
  logic [WIDTH-1:0] b;
  logic             b_ovf;
  logic [WIDTH:0]   sum;
  logic             hs;
  logic             do_load, do_adv, do_wrap, do_ovf;

  assign y_valid = (state == S_RUN);
  assign busy    = (state == S_RUN);
  assign hs      = y_valid & y_ready;
  assign sum     = {1'b0, y} + {1'b0, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_adv    = 1'b0;
    do_wrap   = 1'b0;
    do_ovf    = 1'b0;
    if (stop) begin
      // An accept coinciding with stop completes on the consumer side,
      // but the sequence does not advance.
      state_nxt = S_IDLE;
    end else if (start) begin
      state_nxt = S_RUN;
      do_load   = 1'b1;
    end else if (hs) begin
      if (LIMIT_EN && (idx == LAST_IDX)) begin
        // Term limit beats overflow: the truncated term is never reached.
        do_wrap = 1'b1;
      end else if (b_ovf) begin
        do_ovf = 1'b1;
`ifdef FIB_STOP_ON_OVF_EN
        state_nxt = S_DONE;
`else
        do_wrap = 1'b1;
`endif
      end else begin
        do_adv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0    <= '0;
      s1    <= '0;
      y     <= '0;
      b     <= '0;
      b_ovf <= 1'b0;
      idx   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_load) begin
        s0    <= seed0;
        s1    <= seed1;
        y     <= seed0;
        b     <= seed1;
        b_ovf <= 1'b0;
        idx   <= '0;
        ovf   <= 1'b0;
      end else if (do_wrap) begin
        y     <= s0;
        b     <= s1;
        b_ovf <= 1'b0;
        idx   <= '0;
      end else if (do_adv) begin
        y     <= b;
        b     <= sum[WIDTH-1:0];
        // b_ovf marks that b no longer holds the true next term.
        b_ovf <= b_ovf | sum[WIDTH];
        idx   <= idx + IDX_W'(1);
      end
      if (do_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fib_gen.sv
module tb_fib_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // instance a: default limit of 13 terms
  logic       a_start = 1'b0, a_stop = 1'b0, a_y_ready = 1'b0;
  logic [7:0] a_seed0 = '0, a_seed1 = '0;
  logic [7:0] a_y, a_idx;
  logic       a_y_valid, a_ovf, a_busy;

  // instance b: unlimited terms, runs into overflow
  logic       b_start = 1'b0, b_stop = 1'b0, b_y_ready = 1'b0;
  logic [7:0] b_seed0 = '0, b_seed1 = '0;
  logic [7:0] b_y, b_idx;
  logic       b_y_valid, b_ovf, b_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fib_gen #(.WIDTH(8), .MAX_TERMS(13), .IDX_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop),
    .seed0(a_seed0), .seed1(a_seed1), .y(a_y), .y_valid(a_y_valid),
    .y_ready(a_y_ready), .idx(a_idx), .ovf(a_ovf), .busy(a_busy)
  );

  fib_gen #(.WIDTH(8), .MAX_TERMS(0), .IDX_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
    .seed0(b_seed0), .seed1(b_seed1), .y(b_y), .y_valid(b_y_valid),
    .y_ready(b_y_ready), .idx(b_idx), .ovf(b_ovf), .busy(b_busy)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       ready;
    logic [7:0] sd0;
    logic [7:0] sd1;
    logic [7:0] ey;
    logic       ev;
    logic [7:0] eidx;
    logic       eovf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic rdy,
                     input logic [7:0] s0, input logic [7:0] s1,
                     input logic [7:0] ey, input logic ev,
                     input logic [7:0] eidx, input logic eovf);
    vec_t v;
    v.start = st; v.stop = sp; v.ready = rdy; v.sd0 = s0; v.sd1 = s1;
    v.ey = ey; v.ev = ev; v.eidx = eidx; v.eovf = eovf;
    vq.push_back(v);
  endtask

  task automatic check_a(input string tag, input logic [7:0] ey, input logic ev,
                         input logic [7:0] eidx, input logic eovf);
    check({tag, ".y"},       int'(a_y),       int'(ey));
    check({tag, ".y_valid"}, int'(a_y_valid), int'(ev));
    check({tag, ".idx"},     int'(a_idx),     int'(eidx));
    check({tag, ".ovf"},     int'(a_ovf),     int'(eovf));
    check({tag, ".busy"},    int'(a_busy),    int'(ev));
  endtask

  task automatic check_b(input string tag, input logic [7:0] ey, input logic ev,
                         input logic [7:0] eidx, input logic eovf);
    check({tag, ".y"},       int'(b_y),       int'(ey));
    check({tag, ".y_valid"}, int'(b_y_valid), int'(ev));
    check({tag, ".idx"},     int'(b_idx),     int'(eidx));
    check({tag, ".ovf"},     int'(b_ovf),     int'(eovf));
    check({tag, ".busy"},    int'(b_busy),    int'(ev));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fib[14];
    fib = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

    // ---------------- reset values ----------------
    #12;
    check_a("rst_a", 8'd0, 1'b0, 8'd0, 1'b0);
    check_b("rst_b", 8'd0, 1'b0, 8'd0, 1'b0);
    #10 rst_n = 1'b1;

    // ---------------- table-driven run on instance a ----------------
    add(1, 0, 1, 8'd0, 8'd1, 8'd0, 1, 8'd0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, 0, 1, 8'd0, 8'd1, 8'(fib[k]), 1, 8'(k), 0);
    // backpressure while y=5
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 8'd0, 8'd1, 8'd5, 1, 8'd5, 0);
    for (int k = 6; k <= 12; k++)
      add(0, 0, 1, 8'd0, 8'd1, 8'(fib[k]), 1, 8'(k), 0);
    // term limit reached: wrap to seeds
    add(0, 0, 1, 8'd0, 8'd1, 8'd0, 1, 8'd0, 0);
    add(0, 0, 1, 8'd0, 8'd1, 8'd1, 1, 8'd1, 0);
    add(0, 0, 1, 8'd0, 8'd1, 8'd1, 1, 8'd2, 0);
    // stop with accept in flight: no advance, output drops
    add(0, 1, 1, 8'd0, 8'd1, 8'd1, 0, 8'd2, 0);
    // start & stop together in IDLE: stop wins
    add(1, 1, 1, 8'd2, 8'd5, 8'd1, 0, 8'd2, 0);
    // seeds 2/5
    add(1, 0, 1, 8'd2, 8'd5, 8'd2, 1, 8'd0, 0);
    add(0, 0, 1, 8'd2, 8'd5, 8'd5, 1, 8'd1, 0);
    add(0, 0, 1, 8'd2, 8'd5, 8'd7, 1, 8'd2, 0);
    add(0, 0, 1, 8'd2, 8'd5, 8'd12, 1, 8'd3, 0);
    add(0, 1, 1, 8'd2, 8'd5, 8'd12, 0, 8'd3, 0);
    add(0, 0, 1, 8'd2, 8'd5, 8'd12, 0, 8'd3, 0);

    foreach (vq[i]) begin
      a_start   = vq[i].start;
      a_stop    = vq[i].stop;
      a_y_ready = vq[i].ready;
      a_seed0   = vq[i].sd0;
      a_seed1   = vq[i].sd1;
      tick();
      check_a($sformatf("vec%0d", i), vq[i].ey, vq[i].ev, vq[i].eidx, vq[i].eovf);
    end
    a_start = 1'b0; a_stop = 1'b0; a_y_ready = 1'b0;

    // ---------------- overflow on instance b ----------------
    b_seed0 = 8'd0; b_seed1 = 8'd1; b_y_ready = 1'b1; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check_b("ovf_first", 8'd0, 1'b1, 8'd0, 1'b0);
    for (int k = 1; k <= 13; k++) tick();
    check_b("ovf_last", 8'd233, 1'b1, 8'd13, 1'b0);
    tick();
`ifdef FIB_STOP_ON_OVF_EN
    check_b("ovf_done", 8'd233, 1'b0, 8'd13, 1'b1);
    tick();
    check_b("ovf_hold", 8'd233, 1'b0, 8'd13, 1'b1);
`else
    check_b("ovf_wrap", 8'd0, 1'b1, 8'd0, 1'b1);
    tick();
    check_b("ovf_sticky", 8'd1, 1'b1, 8'd1, 1'b1);
`endif
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check_b("ovf_restart", 8'd0, 1'b1, 8'd0, 1'b0);

    // ---------------- idx wraps modulo 2^IDX_W when unlimited ----------------
    b_seed0 = 8'd0; b_seed1 = 8'd0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= 255; k++) tick();
    check_b("idx_255", 8'd0, 1'b1, 8'd255, 1'b0);
    tick();
    check_b("idx_wrap", 8'd0, 1'b1, 8'd0, 1'b0);
    b_y_ready = 1'b0;

    // ---------------- async reset mid-run on instance a ----------------
    a_seed0 = 8'd0; a_seed1 = 8'd1; a_y_ready = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check_a("pre_rst", 8'd21, 1'b1, 8'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_a("async_rst", 8'd0, 1'b0, 8'd0, 1'b0);
    #10;
    check_a("rst_hold", 8'd0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
